// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared definitions for the in-order memory sequencer.
//   sched_state_e : sequencer FSM encoding (IDLE, ISSUE, WAIT, DRAIN)
//   mem_op_t      : queue entry {is_store, tag, adr, data} at the default
//                   widths (tag 5, address 32, data 32)
//   op_width()    : packed width of a queue entry for arbitrary widths
package mem_sched_pkg;

  localparam int MS_TAG_W  = 5;
  localparam int MS_ADDR_W = 32;
  localparam int MS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic                 is_store;
    logic [MS_TAG_W-1:0]  tag;
    logic [MS_ADDR_W-1:0] adr;
    logic [MS_DATA_W-1:0] data;
  } mem_op_t;

  function automatic int op_width(input int tag_w, input int adr_w, input int data_w);
    return 1 + tag_w + adr_w + data_w;
  endfunction

endpackage

// File: rtl/mem_sched_fifo.sv
// mem_sched_fifo: generic DEPTH-entry circular FIFO with an internal
// occupancy count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop all entries (head = tail = count = 0)
//   push, din  : write din at tail (ignored when full or clearing)
//   pop        : advance head (ignored when empty or clearing)
//   dout       : entry at head (valid when !empty)
//   full/empty : derived from the registered count
module mem_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[head];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[tail] <= din;
  end

endmodule

// File: rtl/mem_sched.sv
// mem_sched: in-order load/store sequencer owning the single ram port.
// Memory ops are queued in program order and issued one at a time using
// the ram start/busy handshake; each completion is broadcast for one cycle.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   enq_valid/enq_ready           : op offer / queue has room
//   enq_is_store, enq_tag,
//   enq_adr, enq_data             : op fields (data ignored for loads)
//   flush                         : discard queued ops, suppress completion
//   mem_start, mem_write,
//   mem_adr, mem_in               : ram request (start is a 1-cycle pulse)
//   mem_out, mem_busy             : ram read data / access in progress
//   res_valid, res_tag,
//   res_is_store, res_data        : completion pulse; fields held until next
// Optional build macro MEM_SCHED_PERF_EN adds perf_loads, perf_stores and
// perf_stall counters (32-bit, wrapping, cleared only by rst).
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic              enq_is_store,
  input  logic [TAG_W-1:0]  enq_tag,
  input  logic [ADDR_W-1:0] enq_adr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              flush,
  output logic              mem_start,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_busy,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_is_store,
  output logic [DATA_W-1:0] res_data
`ifdef MEM_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_stall
`endif
);

  localparam int OP_W = op_width(TAG_W, ADDR_W, DATA_W);

  typedef struct packed {
    logic              is_store;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } op_t;

  op_t              enq_op;
  op_t              head_op;
  logic             q_full;
  logic             q_empty;
  logic             push;
  sched_state_e     state;
  sched_state_e     state_nxt;
  logic             issue_latch;
  logic             complete;
  logic [TAG_W-1:0] cur_tag;

  assign enq_op.is_store = enq_is_store;
  assign enq_op.tag      = enq_tag;
  assign enq_op.adr      = enq_adr;
  assign enq_op.data     = enq_data;

  // Readiness comes from the registered count only, so a full queue refuses
  // an offer even in the cycle its head is popped.
  assign enq_ready = !q_full;
  assign push      = enq_valid && enq_ready && !flush;

  // The head stays queued while its access is in flight; it is popped on
  // completion, so a flush during an access discards it too.
  mem_sched_fifo #(
    .WIDTH (OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (complete),
    .din   (enq_op),
    .dout  (head_op),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue_latch = 1'b0;
    complete    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!q_empty && !flush) begin
          issue_latch = 1'b1;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        // A zero-latency ram never raises busy, so this can be the first cycle.
        if (flush) begin
          state_nxt = ST_DRAIN;
        end else if (!mem_busy) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The abandoned access must still finish before the port is reused.
        if (!mem_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_start = (state == ST_ISSUE);

  // Request register: loaded from the queue head when leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write <= 1'b0;
      mem_adr   <= '0;
      mem_in    <= '0;
      cur_tag   <= '0;
    end else if (issue_latch) begin
      mem_write <= head_op.is_store;
      mem_adr   <= head_op.adr;
      mem_in    <= head_op.data;
      cur_tag   <= head_op.tag;
    end
  end

  // Completion register: one-cycle valid, fields held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_tag      <= '0;
      res_is_store <= 1'b0;
      res_data     <= '0;
    end else begin
      res_valid <= complete;
      if (complete) begin
        res_tag      <= cur_tag;
        res_is_store <= mem_write;
        res_data     <= mem_write ? '0 : mem_out;
      end
    end
  end

`ifdef MEM_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_stall  <= '0;
    end else begin
      if (res_valid && !res_is_store) perf_loads  <= perf_loads + 32'd1;
      if (res_valid && res_is_store)  perf_stores <= perf_stores + 32'd1;
      if (enq_valid && !enq_ready)    perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_sched.md
Name: mem_sched

Overview:
- In-order load/store sequencer that owns the single `ram` port and shares it among the reservation-station load/store entries.
- Accepts address-resolved memory ops in program order and issues them one at a time, using the ram start/busy handshake.
- Broadcasts each completion (tag + data) for one cycle so the reservation stations and register status table can capture it.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- TAG_W, 5, reservation-station tag width
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enq_valid  in  1  new memory op offered
- enq_ready  out  1  queue can accept (count < DEPTH)
- enq_is_store  in  1  1 = store, 0 = load
- enq_tag  in  TAG_W  issuing reservation-station entry
- enq_adr  in  ADDR_W  effective address (base + imm already added)
- enq_data  in  DATA_W  store data; ignored for loads
- flush  in  1  discard all queued ops
- mem_start  out  1  one-cycle access request to ram
- mem_write  out  1  1 = write, 0 = read
- mem_adr  out  ADDR_W  access address
- mem_in  out  DATA_W  write data
- mem_out  in  DATA_W  read data, valid when mem_busy falls
- mem_busy  in  1  ram access in progress
- res_valid  out  1  completion pulse
- res_tag  out  TAG_W  tag of completed op
- res_is_store  out  1  completed op was a store
- res_data  out  DATA_W  load data; 0 for stores

Behaviour:
- Reset: all outputs 0; enq_ready 1; head = tail = count = 0; state IDLE. Reset mid-access abandons the access; no result is produced.
- Queue:
  - Circular FIFO with head/tail pointers modulo DEPTH.
  - Enqueue when enq_valid && enq_ready at the clock edge.
  - enq_ready = (count < DEPTH) from the registered count. A full queue refuses enqueue even when a dequeue occurs in the same cycle.
  - count updates +1 / −1 / 0 for enqueue only / dequeue only / both.
- FSM:
  - IDLE: if count > 0 and not flush, latch the head entry into the mem_* registers and go to ISSUE.
  - ISSUE: mem_start = 1 for exactly this cycle; go to WAIT.
  - WAIT: mem_start = 0. On the first cycle with mem_busy == 0, capture mem_out, pop the head, and pulse res_* next cycle; go to IDLE. A zero-latency ram (busy never rises) therefore completes on the first WAIT cycle.
  - DRAIN: entered from ISSUE or WAIT on flush. Waits for mem_busy == 0, then goes to IDLE with no res_valid and no pop; the queue is already empty.
- Latency: enqueue into an empty queue at edge N → mem_start high cycle N+1 → with ram busy for L cycles, res_valid pulses at cycle N+3+L.
- Back-to-back ops: IDLE→ISSUE means at least one idle cycle between accesses.
- res_valid is high for exactly one cycle. res_tag, res_data and res_is_store are held until the next completion.
- flush:
  - Clears head, tail and count in the same cycle.
  - Enqueue in the flush cycle is ignored.
  - A completion coinciding with flush is suppressed.
- Ordering: strictly program order; no load bypasses an older store.

Optional Feature:
- MEM_SCHED_PERF_EN defined:
  - Adds 32-bit outputs perf_loads, perf_stores and perf_stall.
  - perf_loads and perf_stores count completed ops (res_valid).
  - perf_stall counts cycles with enq_valid && !enq_ready.
  - All three reset to 0, are not cleared by flush, and wrap at 2^32.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header (alongside opcode.h): FSM state encoding (IDLE, ISSUE, WAIT, DRAIN) and the queue entry struct {is_store, tag, adr, data}.
- Sub-module mem_sched_fifo: a generic DEPTH-entry circular FIFO with count, full/empty, push/pop and clear. mem_sched owns the FSM and the ram handshake.

Test Plan:
- Reset then idle: all outputs 0, enq_ready 1; no mem_start for 10 cycles.
- Single load, tag 3, adr 0x10, ram returns 0xDEADBEEF after 2 busy cycles:
  - mem_start one cycle, mem_write 0, mem_adr 0x10.
  - res_valid one cycle with tag 3, data 0xDEADBEEF, is_store 0.
- Store (tag 1, 0x20, 0x55) then load (tag 2, 0x20):
  - Accesses issue in order; store completes first with is_store 1, data 0.
  - Load then returns 0x55.
- Fill DEPTH=4 with ram stalled (busy held):
  - enq_ready drops after the 4th enqueue; a 5th offer is refused.
  - After the first completion, the 5th is accepted next cycle.
- flush during WAIT with 3 queued:
  - No res_valid for any of them; DRAIN until busy falls, then IDLE.
  - A new load after flush issues normally.
- rst asserted in WAIT: mem_start, res_valid and count return to 0 next cycle; the later busy fall produces no result.
